// File: rtl/fetch_npc_gen_pkg.sv
// fetch_npc_gen_pkg: branch/RAS encodings and bundle geometry shared by the fetch next-PC logic
package fetch_npc_gen_pkg;
    localparam logic [1:0] BRTYP_COND     = 2'b00;
    localparam logic [1:0] RASCTL_NONE    = 2'b00;
    localparam logic [1:0] RASCTL_PUSH    = 2'b01;
    localparam logic [1:0] RASCTL_POP     = 2'b10;
    localparam logic [1:0] RASCTL_POPPUSH = 2'b11;
    localparam int         BUNDLE_BYTES   = 32;
    localparam int         INSN_BYTES     = 4;

    // fall-through address just past slot pos of the bundle holding pc
    function automatic logic [63:0] slot_fall(input logic [63:0] pc, input logic [2:0] pos);
        return (pc & ~64'(BUNDLE_BYTES - 1)) + 64'(({1'b0, pos} + 4'd1) * INSN_BYTES);
    endfunction
endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular speculative return address stack with checkpoint restore
module fetch_ras
    import fetch_npc_gen_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             restore,
    input  logic [PTR_W-1:0] ck_tos,
    input  logic [PTR_W:0]   ck_cnt,
    input  logic [1:0]       op,
    input  logic [63:0]      push_val,
    output logic [63:0]      top_o,
    output logic [PTR_W-1:0] tos_o,
    output logic [PTR_W:0]   cnt_o
);
    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] tos, b_tos, n_tos, w_idx;
    logic [PTR_W:0]   cnt, b_cnt, n_cnt;
    logic             wr;

    assign top_o = mem[tos];
    assign tos_o = tos;
    assign cnt_o = cnt;

    // apply this cycle's op on top of either the live or the restored pointer
    always_comb begin
        b_tos = restore ? ck_tos : tos;
        b_cnt = restore ? ck_cnt : cnt;
        n_tos = op == RASCTL_PUSH ? b_tos + PTR_W'(1) :
                (op == RASCTL_POP && b_cnt != '0) ? b_tos - PTR_W'(1) : b_tos;
        n_cnt = clear ? '0 :
                op == RASCTL_PUSH ? (b_cnt == (PTR_W+1)'(DEPTH) ? b_cnt : b_cnt + (PTR_W+1)'(1)) :
                op == RASCTL_POP ? (b_cnt == '0 ? b_cnt : b_cnt - (PTR_W+1)'(1)) :
                op == RASCTL_POPPUSH ? (b_cnt == '0 ? (PTR_W+1)'(1) : b_cnt) : b_cnt;
        wr    = op == RASCTL_PUSH || op == RASCTL_POPPUSH;
        w_idx = op == RASCTL_PUSH ? b_tos + PTR_W'(1) : b_tos;
    end

    // stack storage and pointers; a full push silently overwrites the oldest entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tos <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            tos <= n_tos;
            cnt <= n_cnt;
            if (wr) mem[w_idx] <= push_val;
        end
    end
endmodule

// File: rtl/fetch_npc_gen.sv
// fetch_npc_gen: next fetch PC selection, f0->f1 pipe register and speculative RAS
module fetch_npc_gen
    import fetch_npc_gen_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          RAS_DEPTH = 16,
    parameter int          RAS_PTR_W = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_stall_i,
    input  logic        btb_hit_f0_i,
    input  logic [2:0]  btb_brpos_f0_i,
    input  logic [1:0]  btb_brtyp_f0_i,
    input  logic [63:0] btb_brtar_f0_i,
    input  logic [1:0]  btb_rasctl_f0_i,
    input  logic        btb_brdir_f0_i,
    input  logic        brdec_redirect_f1_i,
    input  logic [63:0] brdec_brtar_f1_i,
    input  logic [2:0]  brdec_brpos_f1_i,
    input  logic [1:0]  brdec_rasctl_f1_i,
    input  logic        redirect_rt_i,
    input  logic [63:0] redirect_pc_rt_i,
    output logic [63:0] pc_f0_o,
    output logic [63:0] pc_f1_o,
    output logic        vld_f1_o,
    output logic        pred_taken_f1_o,
    output logic [63:0] pred_tar_f1_o
);
    logic [63:0]          seq, fall, target, npc, ras_top, push_val;
    logic                 taken;
    logic [1:0]           ras_op;
    logic [RAS_PTR_W-1:0] ras_tos, ck_tos;
    logic [RAS_PTR_W:0]   ras_cnt, ck_cnt;

    // f0 prediction and the RAS action that goes with the winning redirect source
    always_comb begin
        seq      = (pc_f0_o & ~64'(BUNDLE_BYTES - 1)) + 64'(BUNDLE_BYTES);
        fall     = slot_fall(pc_f0_o, btb_brpos_f0_i);
        taken    = btb_hit_f0_i && (btb_brtyp_f0_i != BRTYP_COND || btb_brdir_f0_i);
        target   = (btb_rasctl_f0_i[1] && ras_cnt != '0) ? ras_top : btb_brtar_f0_i;
        npc      = taken ? target : seq;
        ras_op   = redirect_rt_i ? RASCTL_NONE :
                   brdec_redirect_f1_i ? brdec_rasctl_f1_i :
                   (!fetch_stall_i && btb_hit_f0_i) ? btb_rasctl_f0_i : RASCTL_NONE;
        push_val = brdec_redirect_f1_i ? slot_fall(pc_f1_o, brdec_brpos_f1_i) : fall;
    end

    fetch_ras #(
        .DEPTH(RAS_DEPTH),
        .PTR_W(RAS_PTR_W)
    ) u_ras (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (redirect_rt_i),
        .restore (!redirect_rt_i && brdec_redirect_f1_i),
        .ck_tos  (ck_tos),
        .ck_cnt  (ck_cnt),
        .op      (ras_op),
        .push_val(push_val),
        .top_o   (ras_top),
        .tos_o   (ras_tos),
        .cnt_o   (ras_cnt)
    );

    // redirects beat stall; otherwise advance f0 into f1 with its RAS checkpoint
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_f0_o         <= RESET_PC;
            pc_f1_o         <= '0;
            vld_f1_o        <= 1'b0;
            pred_taken_f1_o <= 1'b0;
            pred_tar_f1_o   <= '0;
            ck_tos          <= '0;
            ck_cnt          <= '0;
        end else if (redirect_rt_i) begin
            pc_f0_o  <= redirect_pc_rt_i;
            vld_f1_o <= 1'b0;
        end else if (brdec_redirect_f1_i) begin
            pc_f0_o  <= brdec_brtar_f1_i;
            vld_f1_o <= 1'b0;
        end else if (!fetch_stall_i) begin
            pc_f0_o         <= npc;
            pc_f1_o         <= pc_f0_o;
            vld_f1_o        <= 1'b1;
            pred_taken_f1_o <= taken;
            pred_tar_f1_o   <= target;
            ck_tos          <= ras_tos;
            ck_cnt          <= ras_cnt;
        end
    end
endmodule
